icache_refill: RTL

Refill engine that is the writer side of the icache data RAM. On an icache miss it issues one burst read to memory over a narrow bus and assembles the returned beats into one cache line. It then writes the line and its tag into the icache RAM write port in a single cycle. It sits between the fetch stage (miss source) and the memory interconnect.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_line_buf.sv | 30 +++
 rtl/icache_refill.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants and refill state encoding for the icache refill engine.
// Optional feature macro used by the refill engine: ICACHE_CRIT_WORD_FIRST_EN.
package icache_pkg;

    localparam int unsigned LINE_WIDTH   = 512;
    localparam int unsigned ADDR_BITS    = 9;
    localparam int unsigned BUS_WIDTH    = 64;
    localparam int unsigned PADDR_BITS   = 32;
    localparam int unsigned BEATS        = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned OFFSET_BITS  = $clog2(LINE_WIDTH / 8);
    localparam int unsigned TAG_BITS     = PADDR_BITS - ADDR_BITS - OFFSET_BITS;
    localparam int unsigned BEAT_BITS    = $clog2(BEATS);
    localparam int unsigned BUS_OFF_BITS = $clog2(BUS_WIDTH / 8);

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_REQ   = 2'd1,
        RF_FILL  = 2'd2,
        RF_WRITE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: writes one bus-wide beat into a slot of a
// LINE_WIDTH register, selected by beat index, with synchronous clear.
module icache_line_buf #(
    parameter int unsigned LINE_WIDTH = icache_pkg::LINE_WIDTH,
    parameter int unsigned BUS_WIDTH  = icache_pkg::BUS_WIDTH,
    localparam int unsigned SLOTS     = LINE_WIDTH / BUS_WIDTH,
    localparam int unsigned IDX_W     = $clog2(SLOTS)
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [BUS_WIDTH-1:0]  data_i,
    output logic [LINE_WIDTH-1:0] line_o
);

    logic [LINE_WIDTH-1:0] line_q;

    // Clear has priority over a beat write; otherwise drop the beat into its slot.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            line_q <= '0;
        end else if (we_i) begin
            line_q[idx_i*BUS_WIDTH +: BUS_WIDTH] <= data_i;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/icache_refill.sv
// Icache refill engine: accepts a fetch miss, issues one burst read, assembles
// the returned beats into a line and writes line plus tag in a single cycle.
// Optional feature: `define ICACHE_CRIT_WORD_FIRST_EN for critical-word-first
// wrapping bursts with a forwarded critical beat.
module icache_refill #(
    parameter int unsigned LINE_WIDTH = icache_pkg::LINE_WIDTH,
    parameter int unsigned ADDR_BITS  = icache_pkg::ADDR_BITS,
    parameter int unsigned BUS_WIDTH  = icache_pkg::BUS_WIDTH,
    parameter int unsigned PADDR_BITS = icache_pkg::PADDR_BITS,
    localparam int unsigned OFF_W     = $clog2(LINE_WIDTH / 8),
    localparam int unsigned TAG_W     = PADDR_BITS - ADDR_BITS - OFF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [PADDR_BITS-1:0] miss_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PADDR_BITS-1:0] mem_req_addr_o,
    output logic [7:0]            mem_req_len_o,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,
    input  logic [BUS_WIDTH-1:0]  mem_rsp_data_i,
    input  logic                  mem_rsp_err_i,
    output logic [ADDR_BITS-1:0]  addr_w_o,
    output logic                  we_w_o,
    output logic [LINE_WIDTH-1:0] data_w_o,
    output logic                  tag_we_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  tag_valid_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  crit_valid_o,
    output logic [BUS_WIDTH-1:0]  crit_data_o
);

    import icache_pkg::*;

    localparam int unsigned NBEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned CNT_W  = $clog2(NBEATS);
    localparam int unsigned BOFF_W = $clog2(BUS_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    refill_state_e         state_q;
    logic [ADDR_BITS-1:0]  index_q;
    logic [TAG_W-1:0]      tag_q;
    logic [PADDR_BITS-1:0] req_addr_q;
    logic [7:0]            req_len_q;
    logic                  req_valid_q;
    logic                  rsp_ready_q;
    logic                  miss_ready_q;
    logic                  busy_q;
    logic                  we_q;
    logic                  tag_we_q;
    logic                  tag_valid_q;
    logic                  done_q;
    logic                  err_q;
    logic                  err_sticky_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  miss_fire;
    logic                  beat_fire;
    logic                  err_now;
    logic                  last_beat;
    logic [PADDR_BITS-1:0] req_addr_d;
    logic [CNT_W-1:0]      cnt_start;
    logic [LINE_WIDTH-1:0] line;

    assign miss_fire = (state_q == RF_IDLE) && miss_valid_i && miss_ready_q;
    assign beat_fire = (state_q == RF_FILL) && rsp_ready_q && mem_rsp_valid_i;
    assign err_now   = err_sticky_q | mem_rsp_err_i;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    logic [CNT_W-1:0]     seen_q;
    logic                 crit_valid_q;
    logic [BUS_WIDTH-1:0] crit_data_q;
    logic                 unused_addr;

    // Slot index wraps with cnt_q; completion is counted separately in seen_q.
    assign req_addr_d  = {miss_addr_i[PADDR_BITS-1:BOFF_W], {BOFF_W{1'b0}}};
    assign cnt_start   = req_addr_q[OFF_W-1:BOFF_W];
    assign last_beat   = (seen_q == LAST_CNT);
    assign unused_addr = ^miss_addr_i[BOFF_W-1:0];
    assign crit_valid_o = crit_valid_q;
    assign crit_data_o  = crit_data_q;
`else
    logic unused_addr;

    assign req_addr_d   = {miss_addr_i[PADDR_BITS-1:OFF_W], {OFF_W{1'b0}}};
    assign cnt_start    = '0;
    assign last_beat    = (cnt_q == LAST_CNT);
    assign unused_addr  = ^miss_addr_i[OFF_W-1:0];
    assign crit_valid_o = 1'b0;
    assign crit_data_o  = '0;
`endif

    // Beat assembly; cleared on reset and at the start of every refill.
    icache_line_buf #(
        .LINE_WIDTH (LINE_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_line_buf (
        .clk    (clk),
        .clr_i  (rst | miss_fire),
        .we_i   (beat_fire),
        .idx_i  (cnt_q),
        .data_i (mem_rsp_data_i),
        .line_o (line)
    );

    // Refill FSM with registered handshake and write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RF_IDLE;
            index_q      <= '0;
            tag_q        <= '0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
            req_valid_q  <= 1'b0;
            rsp_ready_q  <= 1'b0;
            miss_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            tag_we_q     <= 1'b0;
            tag_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            cnt_q        <= '0;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
            seen_q       <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
`endif
        end else begin
            we_q        <= 1'b0;
            tag_we_q    <= 1'b0;
            tag_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
            crit_valid_q <= 1'b0;
`endif
            unique case (state_q)
                RF_IDLE: begin
                    miss_ready_q <= 1'b1;
                    if (miss_fire) begin
                        index_q      <= miss_addr_i[OFF_W +: ADDR_BITS];
                        tag_q        <= miss_addr_i[PADDR_BITS-1 -: TAG_W];
                        req_addr_q   <= req_addr_d;
                        req_len_q    <= 8'(NBEATS - 1);
                        err_sticky_q <= 1'b0;
                        miss_ready_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= RF_REQ;
                    end
                end
                RF_REQ: begin
                    if (mem_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        cnt_q       <= cnt_start;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
                        seen_q      <= '0;
`endif
                        state_q     <= RF_FILL;
                    end
                end
                RF_FILL: begin
                    if (beat_fire) begin
                        cnt_q        <= cnt_q + 1'b1;
                        err_sticky_q <= err_now;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
                        seen_q <= seen_q + 1'b1;
                        if (seen_q == '0) begin
                            crit_valid_q <= 1'b1;
                            crit_data_q  <= mem_rsp_data_i;
                        end
`endif
                        if (last_beat) begin
                            rsp_ready_q <= 1'b0;
                            we_q        <= ~err_now;
                            tag_we_q    <= 1'b1;
                            tag_valid_q <= ~err_now;
                            done_q      <= 1'b1;
                            err_q       <= err_now;
                            state_q     <= RF_WRITE;
                        end
                    end
                end
                RF_WRITE: begin
                    busy_q       <= 1'b0;
                    miss_ready_q <= 1'b1;
                    state_q      <= RF_IDLE;
                end
                default: begin
                    state_q <= RF_IDLE;
                end
            endcase
        end
    end

    assign miss_ready_o    = miss_ready_q;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_len_o   = req_len_q;
    assign mem_rsp_ready_o = rsp_ready_q;
    assign addr_w_o        = index_q;
    assign we_w_o          = we_q;
    assign data_w_o        = line;
    assign tag_we_o        = tag_we_q;
    assign tag_o           = tag_q;
    assign tag_valid_o     = tag_valid_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign busy_o          = busy_q;

endmodule
